// File: rtl/dm_byte_store.sv
// Word-organised data memory with sb/sh/sw store merging and store address error detection.
// Optional build macro: DM_TRACE_EN prints one trace line per committed write.
module dm_byte_store #(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [1:0]  store_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] dm_out,
    output logic [3:0]  byte_en,
    output logic        ades
);

    localparam logic [1:0] OP_SW  = 2'b00;
    localparam logic [1:0] OP_SB  = 2'b01;
    localparam logic [1:0] OP_SH  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic [31:0]            mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] valid;
    logic [ADDR_W-1:0]      idx;
    logic                   in_range;
    logic                   misaligned;
    logic [3:0]             lanes;
    logic [31:0]            wrep;
    logic [31:0]            old_word;
    logic [31:0]            merged;

    assign idx      = addr[ADDR_W+1:2];
    assign in_range = (addr[31:ADDR_W+2] == '0);

    always_comb begin
        lanes = 4'b0000;
        wrep  = wdata;
        unique case (store_op)
            OP_SW: begin
                lanes = 4'b1111;
                wrep  = wdata;
            end
            OP_SB: begin
                lanes = 4'b0001 << addr[1:0];
                wrep  = {4{wdata[7:0]}};
            end
            OP_SH: begin
                lanes = addr[1] ? 4'b1100 : 4'b0011;
                wrep  = {2{wdata[15:0]}};
            end
            default: begin
                lanes = 4'b0000;
                wrep  = wdata;
            end
        endcase
    end

    assign misaligned = ((store_op == OP_SW) && (addr[1:0] != 2'b00)) ||
                        ((store_op == OP_SH) && addr[0]);
    assign ades       = mem_we && (misaligned || ((store_op != OP_RSV) && !in_range));
    assign byte_en    = (mem_we && !ades) ? lanes : 4'b0000;

    // A word never written since reset reads as zero; this gives the instant whole-array clear.
    assign old_word = valid[idx] ? mem[idx] : 32'h0;
    assign dm_out   = in_range ? old_word : 32'h0;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = wrep[8*i +: 8];
        end
    end

    // The full merged word is stored so stale contents behind a cleared valid bit never leak.
    always_ff @(posedge clk) begin
        if (!reset && (byte_en != 4'b0000)) mem[idx] <= merged;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (byte_en != 4'b0000) begin
            valid[idx] <= 1'b1;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && (byte_en != 4'b0000))
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_byte_store.sv
// Self-checking bench for dm_byte_store: byte-addressed reference model, per-cycle compare,
// directed literal scenarios, randomized stores and asynchronous reset checks.
module tb_dm_byte_store;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_we = 1'b0;
    logic [1:0]  store_op = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] dm_out;
    logic [3:0]  byte_en;
    logic        ades;

    int checks = 0;
    int errors = 0;
    logic [7:0]  mb [0:16383];
    logic [31:0] exp_q [$];

    dm_byte_store dut (
        .clk      (clk),
        .reset    (reset),
        .mem_we   (mem_we),
        .store_op (store_op),
        .addr     (addr),
        .wdata    (wdata),
        .pc       (pc),
        .dm_out   (dm_out),
        .byte_en  (byte_en),
        .ades     (ades)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (byte addressed) ----------------
    function automatic int unsigned op_size(input logic [1:0] op);
        case (op)
            2'b00:   return 4;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic m_ades(input logic we, input logic [1:0] op, input logic [31:0] a);
        int unsigned sz;
        sz = op_size(op);
        if (!we || sz == 0) return 1'b0;
        return ((a % sz) != 0) || (a >= 32'h4000);
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [1:0] op, input logic [31:0] a);
        logic [3:0] be;
        int unsigned sz;
        be = 4'b0000;
        sz = op_size(op);
        if (we && sz != 0 && !m_ades(we, op, a)) begin
            for (int b = 0; b < int'(sz); b++) be[int'(a[1:0]) + b] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int base;
        if (a >= 32'h4000) return 32'h0;
        base = int'(a[13:2]) * 4;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
        end else if (m_be(mem_we, store_op, addr) != 4'b0000) begin
            for (int b = 0; b < int'(op_size(store_op)); b++)
                mb[int'(addr[13:0]) + b] = wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: addr=%h got %h expected %h at %0t", name, addr, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("dm_out", dm_out, m_read(addr));
        chk("byte_en", {28'h0, byte_en}, {28'h0, m_be(mem_we, store_op, addr)});
        chk("ades", {31'h0, ades}, {31'h0, m_ades(mem_we, store_op, addr)});
        if (exp_q.size() > 0) chk("rd_queue", dm_out, exp_q.pop_front());
    end

    // ---------------- driver ----------------
    task automatic drive(input logic we, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        mem_we   = we;
        store_op = op;
        addr     = a;
        wdata    = d;
        pc       = 32'h3000 + a;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        drive(1'b0, 2'b00, 32'h0, 32'h0);
        settle();
        chk("reset_state", dm_out, 32'h0);

        for (int i = 0; i < 4096; i++) drive(1'b0, 2'b00, 32'(i * 4), 32'h0);

        // sw then sb into the same word
        drive(1'b1, 2'b00, 32'h10, 32'h12345678);
        drive(1'b1, 2'b01, 32'h12, 32'h000000AB);
        settle();
        chk("sb_be", {28'h0, byte_en}, 32'h4);
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        settle();
        chk("sb_merge", dm_out, 32'h12AB5678);

        // halfword store and misaligned halfword
        drive(1'b1, 2'b10, 32'h22, 32'h0000BEEF);
        settle();
        chk("sh_be", {28'h0, byte_en}, 32'hC);
        drive(1'b0, 2'b00, 32'h20, 32'h0);
        settle();
        chk("sh_merge", dm_out, 32'hBEEF0000);
        drive(1'b1, 2'b10, 32'h21, 32'h00001234);
        settle();
        chk("sh_mis_ades", {31'h0, ades}, 32'h1);
        chk("sh_mis_be", {28'h0, byte_en}, 32'h0);
        drive(1'b0, 2'b00, 32'h20, 32'h0);
        settle();
        chk("sh_mis_nowr", dm_out, 32'hBEEF0000);

        // out of range, misaligned word, reserved op
        drive(1'b1, 2'b00, 32'h4000, 32'hFFFFFFFF);
        settle();
        chk("oor_ades", {31'h0, ades}, 32'h1);
        chk("oor_dm", dm_out, 32'h0);
        drive(1'b1, 2'b00, 32'h6, 32'hFFFFFFFF);
        settle();
        chk("sw_mis_ades", {31'h0, ades}, 32'h1);
        drive(1'b0, 2'b00, 32'h4, 32'h0);
        settle();
        chk("sw_mis_nowr", dm_out, 32'h0);
        drive(1'b1, 2'b11, 32'h10, 32'hFFFFFFFF);
        settle();
        chk("rsv_ades", {31'h0, ades}, 32'h0);
        chk("rsv_be", {28'h0, byte_en}, 32'h0);
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        settle();
        chk("rsv_nowr", dm_out, 32'h12AB5678);

        // back-to-back byte stores to one word
        drive(1'b1, 2'b01, 32'h30, 32'h00000011);
        drive(1'b1, 2'b01, 32'h33, 32'h00000022);
        settle();
        chk("b2b_old", dm_out, 32'h00000011);
        chk("b2b_be", {28'h0, byte_en}, 32'h8);
        drive(1'b0, 2'b00, 32'h30, 32'h0);
        settle();
        chk("b2b_merge", dm_out, 32'h22000011);

        // highest in-range word
        drive(1'b1, 2'b00, 32'h3FFC, 32'hDEADBEEF);
        drive(1'b0, 2'b00, 32'h3FFC, 32'h0);
        settle();
        chk("top_word", dm_out, 32'hDEADBEEF);

        // randomized stores and reads
        repeat (2000) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 63));
            else if (r < 9) a = 32'h3FF0 + 32'($urandom_range(0, 23));
            else            a = $urandom;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, $urandom);
            exp_q.push_back(m_read(addr));
        end

        // asynchronous reset mid-run, with a store attempted while reset is high
        drive(1'b1, 2'b00, 32'h10, 32'hA5A5A5A5);
        drive(1'b0, 2'b00, 32'h10, 32'h0);
        settle();
        chk("pre_reset", dm_out, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_async", dm_out, 32'h0);
        mem_we   = 1'b1;
        store_op = 2'b00;
        addr     = 32'h14;
        wdata    = 32'h55555555;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mem_we = 1'b0;
        settle();
        chk("reset_drop", dm_out, 32'h0);

        for (int i = 0; i < 4096; i++) drive(1'b0, 2'b00, 32'(i * 4), 32'h0);

        drive(1'b0, 2'b00, 32'h0, 32'h0);
        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
